phase_scheduler: RTL and testbench

- Demand-actuated phase scheduler for the intersection lamp sequencer.
- Latches vehicle-detector requests for street B and walk-button requests, and chooses the next phase (A main, B side, W walk) each time the sequencer reports a phase complete.
- Issues that phase over a go/done handshake; A is the default rest phase.
- Also handles maintenance override, walk anti-starvation and a sequencer-hang watchdog.

---
 rtl/phase_scheduler.sv | 116 +++++++++++
 tb/tb_phase_scheduler.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/phase_scheduler.sv
// Demand-actuated phase scheduler: latches B/walk requests, picks the next lamp phase
// on each phase_done, and handles maintenance override, walk aging and a hang watchdog.
module phase_scheduler #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 1,
  parameter int MAX_WAIT_T  = 30,
  parameter int DONE_TMO_T  = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       MAINT,
  input  logic       req_b,
  input  logic       req_w,
  input  logic       phase_done,
  output logic       phase_go,
  output logic [1:0] phase_sel,
  output logic       pend_b,
  output logic       pend_w,
  output logic       busy,
  output logic       fault
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int AW  = $clog2(MAX_WAIT_T + 1);
  localparam int TW  = $clog2(DONE_TMO_T + 1);

  typedef enum logic [1:0] {ISSUE, WAIT_DONE, MAINT_S, FAULT} state_t;
  typedef enum logic [1:0] {PH_A = 2'b00, PH_B = 2'b01, PH_W = 2'b10, PH_M = 2'b11} phase_t;

  state_t        state, prev_state, state_nx;
  phase_t        last, sel_q, dec, sel_o;
  logic [PW-1:0] pre;
  logic [AW-1:0] w_age;
  logic [TW-1:0] tmo;
  logic          tick, issue_b, issue_w;

  assign tick = (pre == PW'(DIV - 1));

  // An ISSUE entered straight from MAINT_S always serves A.
  always_comb begin
    dec = PH_A;
    if (prev_state == MAINT_S) begin
      dec = PH_A;
    end else if (pend_w && (w_age == AW'(MAX_WAIT_T))) begin
      dec = PH_W;
    end else begin
      case (last)
        PH_A:    dec = pend_b ? PH_B : (pend_w ? PH_W : PH_A);
        PH_B:    dec = pend_w ? PH_W : PH_A;
        default: dec = pend_b ? PH_B : PH_A;
      endcase
    end
  end

  assign issue_b = (state == ISSUE) && (dec == PH_B);
  assign issue_w = (state == ISSUE) && (dec == PH_W);

  always_comb begin
    state_nx = state;
    case (state)
      ISSUE:     state_nx = MAINT ? MAINT_S : WAIT_DONE;
      WAIT_DONE: begin
        if (MAINT)                          state_nx = MAINT_S;
        else if (phase_done)                state_nx = ISSUE;
        else if (tmo == TW'(DONE_TMO_T))    state_nx = FAULT;
      end
      MAINT_S:   if (!MAINT) state_nx = ISSUE;
      default:   state_nx = FAULT;
    endcase
  end

  // MAINT_S/FAULT pulse go only in the cycle they are entered.
  always_comb begin
    phase_go = !reset && ((state == ISSUE) ||
               (((state == MAINT_S) || (state == FAULT)) && (prev_state != state)));
    sel_o = sel_q;
    if (state == ISSUE)                            sel_o = dec;
    else if ((state == MAINT_S) || (state == FAULT)) sel_o = PH_M;
    phase_sel = sel_o;
    busy  = (state == WAIT_DONE);
    fault = (state == FAULT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ISSUE;
      prev_state <= ISSUE;
      last       <= PH_W;
      sel_q      <= PH_A;
      pend_b     <= 1'b0;
      pend_w     <= 1'b0;
      pre        <= '0;
      w_age      <= '0;
      tmo        <= '0;
    end else begin
      prev_state <= state;
      state      <= state_nx;
      pre        <= tick ? '0 : pre + 1'b1;
      pend_b     <= issue_b ? 1'b0 : (pend_b | req_b);
      pend_w     <= issue_w ? 1'b0 : (pend_w | req_w);
      if (issue_w || !pend_w)
        w_age <= '0;
      else if (tick && (w_age != AW'(MAX_WAIT_T)))
        w_age <= w_age + 1'b1;
      if (state == ISSUE) begin
        tmo   <= '0;
        last  <= dec;
        sel_q <= dec;
      end else if ((state == WAIT_DONE) && tick && (tmo != TW'(DONE_TMO_T))) begin
        tmo <= tmo + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_phase_scheduler.sv
// Bench for phase_scheduler: directed vector table, multi-cycle corner sequences and
// random traffic, all compared against a cycle-count based reference model.
module tb_phase_scheduler;
  localparam int DIV  = 10;
  localparam int MAXW = 3;
  localparam int TMO  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1, MAINT = 1'b0, req_b = 1'b0, req_w = 1'b0, phase_done = 1'b0;
  logic       phase_go, pend_b, pend_w, busy, fault;
  logic [1:0] phase_sel;

  int unsigned n_chk = 0, n_pass = 0;
  logic [6:0]  obs;

  always #5 clk = ~clk;

  phase_scheduler #(
    .CLK_FREQ_HZ(1000), .TICK_HZ(100), .MAX_WAIT_T(MAXW), .DONE_TMO_T(TMO)
  ) dut (
    .clk(clk), .reset(reset), .MAINT(MAINT), .req_b(req_b), .req_w(req_w),
    .phase_done(phase_done), .phase_go(phase_go), .phase_sel(phase_sel),
    .pend_b(pend_b), .pend_w(pend_w), .busy(busy), .fault(fault)
  );

  // Reference model: mode 0 issue, 1 waiting, 2 maintenance, 3 fault.
  // Timers are derived from cycle numbers since reset rather than held as counters.
  bit known = 0;
  int mode, last, hold, p, w_set, go_cyc;
  bit entry, from_maint, mb, mw;

  function automatic int ticks(int a, int b);
    if (b < a) return 0;
    return (b + 1) / DIV - a / DIV;
  endfunction

  function automatic int age();
    int t;
    if (!mw) return 0;
    t = ticks(w_set, p - 1);
    return (t > MAXW) ? MAXW : t;
  endfunction

  function automatic int decide();
    if (from_maint) return 0;
    if (mw && age() == MAXW) return 2;
    case (last)
      0:       return mb ? 1 : (mw ? 2 : 0);
      1:       return mw ? 2 : 0;
      default: return mb ? 1 : 0;
    endcase
  endfunction

  function automatic logic [6:0] model_out(bit r);
    logic       go;
    logic [1:0] sel;
    go  = !r && (mode == 0 || (mode >= 2 && entry));
    sel = (mode == 0) ? 2'(decide()) : (mode >= 2) ? 2'b11 : 2'(hold);
    return {go, sel, mb, mw, (mode == 1), (mode == 3)};
  endfunction

  task automatic model_advance(bit r, bit m, bit rb, bit rw, bit d);
    int dc, tm;
    bit nb, nw;
    if (r) begin
      known = 1; mode = 0; entry = 0; from_maint = 0; mb = 0; mw = 0;
      last = 2; hold = 0; p = 0; w_set = 0; go_cyc = 0;
      return;
    end
    dc = decide();
    tm = ticks(go_cyc + 1, p - 1);
    nb = (mode == 0 && dc == 1) ? 1'b0 : (mb | rb);
    nw = (mode == 0 && dc == 2) ? 1'b0 : (mw | rw);
    if (nw && !mw) w_set = p + 1;
    entry = 0;
    from_maint = 0;
    case (mode)
      0: begin
        last = dc; hold = dc; go_cyc = p;
        mode = m ? 2 : 1;
        entry = m;
      end
      1: begin
        if (m) begin mode = 2; entry = 1; end
        else if (d) mode = 0;
        else if (tm >= TMO) begin mode = 3; entry = 1; end
      end
      2: if (!m) begin mode = 0; from_maint = 1; end
      default: ;
    endcase
    mb = nb;
    mw = nw;
    p++;
  endtask

  task automatic cmp(string tag, logic [6:0] got, logic [6:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0t got{go,sel,pb,pw,busy,fault}=%b expected=%b", tag, $time, got, exp);
  endtask

  task automatic want(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s t=%0t got=%0d expected=%0d", tag, $time, got, exp);
  endtask

  // One clock cycle: drive, sample mid-cycle against the model, then clock the model.
  task automatic step(bit r, bit m, bit rb, bit rw, bit d);
    reset = r; MAINT = m; req_b = rb; req_w = rw; phase_done = d;
    #1;
    obs = {phase_go, phase_sel, pend_b, pend_w, busy, fault};
    if (known) cmp("model", obs, model_out(r));
    @(posedge clk);
    model_advance(r, m, rb, rw, d);
    #1;
  endtask

  typedef struct {
    bit r, m, rb, rw, d;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 0, 7'b0000000};
    tbl[1]  = '{0, 0, 1, 0, 0, 7'b1000000};
    tbl[2]  = '{0, 0, 0, 1, 0, 7'b0001010};
    tbl[3]  = '{0, 0, 0, 0, 1, 7'b0001110};
    tbl[4]  = '{0, 0, 0, 0, 0, 7'b1011100};
    tbl[5]  = '{0, 0, 0, 0, 0, 7'b0010110};
    tbl[6]  = '{0, 0, 0, 0, 1, 7'b0010110};
    tbl[7]  = '{0, 0, 0, 1, 0, 7'b1100100};
    tbl[8]  = '{0, 0, 0, 0, 0, 7'b0100010};
    tbl[9]  = '{0, 1, 0, 0, 0, 7'b0100010};
    tbl[10] = '{0, 1, 0, 0, 1, 7'b1110000};
    tbl[11] = '{0, 1, 1, 0, 0, 7'b0110000};
    tbl[12] = '{0, 0, 0, 0, 0, 7'b0111000};
    tbl[13] = '{0, 0, 0, 0, 0, 7'b1001000};
    tbl[14] = '{0, 0, 0, 0, 0, 7'b0001010};

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].r, tbl[i].m, tbl[i].rb, tbl[i].rw, tbl[i].d);
      cmp($sformatf("table[%0d]", i), obs, tbl[i].exp);
    end

    // Idle rotation: A every time, go one cycle after done.
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 0);
      want("idle_go", int'(obs[6]), 1);
      want("idle_sel", int'(obs[5:4]), 0);
      for (int j = 0; j < 19; j++) step(0, 0, 0, 0, 0);
      want("idle_busy", int'(obs[1]), 1);
      step(0, 0, 0, 0, 1);
    end

    // Aged walk request beats a pending B that rotation would prefer.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    for (int j = 0; j < 40; j++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    want("age_go", int'(obs[6]), 1);
    want("age_sel", int'(obs[5:4]), 2);

    // Watchdog: no done ever; MAINT toggles after the fault must not matter.
    step(1, 0, 0, 0, 0);
    for (int j = 0; j < 120; j++) begin
      automatic logic [31:0] jj = 32'(j);
      step(0, (j > 90) ? jj[2] : 1'b0, 0, 0, 0);
    end
    want("wdog_fault", int'(obs[0]), 1);
    want("wdog_sel", int'(obs[5:4]), 3);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    want("wdog_clear", int'(obs[0]), 0);
    want("wdog_restart", int'({obs[6], obs[5:4]}), 4);

    // Random traffic.
    for (int j = 0; j < 3000; j++) begin
      automatic bit r  = ($urandom_range(0, 499) == 0);
      automatic bit m  = (MAINT && $urandom_range(0, 19) != 0) || ($urandom_range(0, 79) == 0);
      automatic bit rb = ($urandom_range(0, 15) == 0);
      automatic bit rw = ($urandom_range(0, 19) == 0);
      automatic bit d  = ($urandom_range(0, 12) == 0);
      step(r, m, rb, rw, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
